id_ex_alu_decode: RTL and testbench

Instruction-decode-to-execute stage register that turns a fetched MIPS instruction plus register-file read data into the operand/command bundle consumed by the execute-stage ALU. It is the producer end of the ALU `cmd`/operand interface: one cycle of latency, with stall (hold) and flush (bubble) control from the hazard unit. A sticky flag records any unsupported encoding.

---
 rtl/id_ex_alu_decode.sv | 197 +++++++++++++++++++
 tb/tb_id_ex_alu_decode.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/id_ex_alu_decode.sv
// ID/EX stage register: decodes a MIPS instruction into the ALU operand/command
// bundle, with stall (hold), flush (bubble) and a sticky unsupported-encoding flag.
module id_ex_alu_decode (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        in_valid,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        stall,
  input  logic        flush,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_cmd,
  output logic [31:0] store_data,
  output logic        wb_en,
  output logic [4:0]  wb_reg,
  output logic        mem_read,
  output logic        mem_write,
  output logic        out_valid,
  output logic        illegal,
  output logic        illegal_seen
);

  localparam logic [3:0] CMD_ADD    = 4'd0;
  localparam logic [3:0] CMD_SUB    = 4'd2;
  localparam logic [3:0] CMD_AND    = 4'd4;
  localparam logic [3:0] CMD_OR     = 4'd5;
  localparam logic [3:0] CMD_NOR    = 4'd6;
  localparam logic [3:0] CMD_XOR    = 4'd7;
  localparam logic [3:0] CMD_LEFT   = 4'd8;
  localparam logic [3:0] CMD_SRIGHT = 4'd9;
  localparam logic [3:0] CMD_RIGHT  = 4'd10;

  logic [5:0]  op, funct;
  logic [4:0]  rt, rd, shamt;
  logic [31:0] sx, zx;

  assign op    = instr[31:26];
  assign rt    = instr[20:16];
  assign rd    = instr[15:11];
  assign shamt = instr[10:6];
  assign funct = instr[5:0];
  assign sx    = {{16{instr[15]}}, instr[15:0]};
  assign zx    = {16'b0, instr[15:0]};

  logic [31:0] dec_a, dec_b;
  logic [3:0]  dec_cmd;
  logic [4:0]  dec_wb_reg;
  logic        dec_writes, dec_wb_en, dec_mr, dec_mw, dec_ill;

  always_comb begin
    dec_a      = rs_data;
    dec_b      = rt_data;
    dec_cmd    = CMD_ADD;
    dec_wb_reg = rt;
    dec_writes = 1'b1;
    dec_mr     = 1'b0;
    dec_mw     = 1'b0;
    dec_ill    = 1'b0;
    case (op)
      6'h00: begin
        dec_wb_reg = rd;
        case (funct)
          6'h20, 6'h21: dec_cmd = CMD_ADD;
          6'h22, 6'h23: dec_cmd = CMD_SUB;
          6'h24: dec_cmd = CMD_AND;
          6'h25: dec_cmd = CMD_OR;
          6'h26: dec_cmd = CMD_XOR;
          6'h27: dec_cmd = CMD_NOR;
          6'h00, 6'h02, 6'h03: begin
            dec_a   = rt_data;
            dec_b   = {27'b0, shamt};
            dec_cmd = (funct == 6'h00) ? CMD_LEFT :
                      (funct == 6'h02) ? CMD_RIGHT : CMD_SRIGHT;
          end
          6'h04, 6'h06, 6'h07: begin
            dec_a   = rt_data;
            dec_b   = {27'b0, rs_data[4:0]};
            dec_cmd = (funct == 6'h04) ? CMD_LEFT :
                      (funct == 6'h06) ? CMD_RIGHT : CMD_SRIGHT;
          end
          default: dec_ill = 1'b1;
        endcase
      end
      6'h08, 6'h09: dec_b = sx;
      6'h0C: begin dec_b = zx; dec_cmd = CMD_AND; end
      6'h0D: begin dec_b = zx; dec_cmd = CMD_OR;  end
      6'h0E: begin dec_b = zx; dec_cmd = CMD_XOR; end
      6'h0F: begin
        dec_a   = zx;
        dec_b   = 32'd16;
        dec_cmd = CMD_LEFT;
      end
      6'h23: begin dec_b = sx; dec_mr = 1'b1; end
      6'h2B: begin dec_b = sx; dec_mw = 1'b1; dec_writes = 1'b0; end
      default: dec_ill = 1'b1;
    endcase
    // Unsupported encodings collapse to a harmless ADD 0,0 with no side effects
    if (dec_ill) begin
      dec_a      = 32'b0;
      dec_b      = 32'b0;
      dec_cmd    = CMD_ADD;
      dec_wb_reg = 5'b0;
      dec_writes = 1'b0;
    end
  end

  assign dec_wb_en = dec_writes && (dec_wb_reg != 5'd0);

  logic [31:0] a_q, a_d, b_q, b_d, sd_q, sd_d;
  logic [3:0]  cmd_q, cmd_d;
  logic [4:0]  wbr_q, wbr_d;
  logic        wbe_q, wbe_d, mr_q, mr_d, mw_q, mw_d;
  logic        ov_q, ov_d, ill_q, ill_d, seen_q, seen_d;
  logic        load;

  assign load = !flush && !stall && in_valid;

  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    sd_d   = sd_q;
    cmd_d  = cmd_q;
    wbr_d  = wbr_q;
    wbe_d  = wbe_q;
    mr_d   = mr_q;
    mw_d   = mw_q;
    ov_d   = ov_q;
    ill_d  = ill_q;
    seen_d = seen_q | (load & dec_ill);
    if (flush || (!stall && !in_valid)) begin
      a_d   = 32'b0;
      b_d   = 32'b0;
      sd_d  = 32'b0;
      cmd_d = 4'b0;
      wbr_d = 5'b0;
      wbe_d = 1'b0;
      mr_d  = 1'b0;
      mw_d  = 1'b0;
      ov_d  = 1'b0;
      ill_d = 1'b0;
    end else if (load) begin
      a_d   = dec_a;
      b_d   = dec_b;
      sd_d  = rt_data;
      cmd_d = dec_cmd;
      wbr_d = dec_wb_reg;
      wbe_d = dec_wb_en;
      mr_d  = dec_mr;
      mw_d  = dec_mw;
      ov_d  = 1'b1;
      ill_d = dec_ill;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q    <= 32'b0;
      b_q    <= 32'b0;
      sd_q   <= 32'b0;
      cmd_q  <= 4'b0;
      wbr_q  <= 5'b0;
      wbe_q  <= 1'b0;
      mr_q   <= 1'b0;
      mw_q   <= 1'b0;
      ov_q   <= 1'b0;
      ill_q  <= 1'b0;
      seen_q <= 1'b0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      sd_q   <= sd_d;
      cmd_q  <= cmd_d;
      wbr_q  <= wbr_d;
      wbe_q  <= wbe_d;
      mr_q   <= mr_d;
      mw_q   <= mw_d;
      ov_q   <= ov_d;
      ill_q  <= ill_d;
      seen_q <= seen_d;
    end
  end

  assign alu_a        = a_q;
  assign alu_b        = b_q;
  assign alu_cmd      = cmd_q;
  assign store_data   = sd_q;
  assign wb_en        = wbe_q;
  assign wb_reg       = wbr_q;
  assign mem_read     = mr_q;
  assign mem_write    = mw_q;
  assign out_valid    = ov_q;
  assign illegal      = ill_q;
  assign illegal_seen = seen_q;

endmodule

// File: tb/tb_id_ex_alu_decode.sv
// Directed bench for id_ex_alu_decode: each step queues its expected bundle,
// which is popped and compared field by field one edge later.
module tb_id_ex_alu_decode;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, stall, flush;
  logic [31:0] instr, rs_data, rt_data;
  logic [31:0] alu_a, alu_b, store_data;
  logic [3:0]  alu_cmd;
  logic        wb_en, mem_read, mem_write, out_valid, illegal, illegal_seen;
  logic [4:0]  wb_reg;

  always #5 clk = ~clk;

  id_ex_alu_decode dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .in_valid(in_valid),
    .rs_data(rs_data), .rt_data(rt_data), .stall(stall), .flush(flush),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cmd(alu_cmd), .store_data(store_data),
    .wb_en(wb_en), .wb_reg(wb_reg), .mem_read(mem_read), .mem_write(mem_write),
    .out_valid(out_valid), .illegal(illegal), .illegal_seen(illegal_seen)
  );

  typedef struct {
    string       tag;
    logic [31:0] a, b, sd;
    logic [3:0]  cmd;
    logic        wbe;
    logic [4:0]  wbr;
    logic        mr, mw, ov, ill, seen;
  } exp_t;

  exp_t sb[$];
  exp_t last;
  int   n_vec = 0;
  int   n_err = 0;

  function automatic exp_t mk(string tag, logic [31:0] a, logic [31:0] b,
                              logic [3:0] cmd, logic [31:0] sd, logic wbe,
                              logic [4:0] wbr, logic mr, logic mw, logic ov,
                              logic ill, logic seen);
    exp_t e;
    e.tag = tag; e.a = a; e.b = b; e.cmd = cmd; e.sd = sd; e.wbe = wbe;
    e.wbr = wbr; e.mr = mr; e.mw = mw; e.ov = ov; e.ill = ill; e.seen = seen;
    return e;
  endfunction

  function automatic exp_t bubble(string tag, logic seen);
    return mk(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, seen);
  endfunction

  task automatic chk32(string tag, string f, logic [31:0] obs, logic [31:0] e);
    n_vec++;
    assert (obs === e) else begin
      n_err++;
      $error("FAIL %s.%s observed=%h expected=%h", tag, f, obs, e);
    end
  endtask

  // Drive one cycle of inputs, queue its expectation, then check after the edge.
  task automatic step(logic rn, logic [31:0] ins, logic v, logic [31:0] rs,
                      logic [31:0] rt, logic st, logic fl, exp_t e);
    exp_t got;
    rst_n = rn; instr = ins; in_valid = v; rs_data = rs; rt_data = rt;
    stall = st; flush = fl;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    chk32(got.tag, "alu_a",      alu_a,               got.a);
    chk32(got.tag, "alu_b",      alu_b,               got.b);
    chk32(got.tag, "alu_cmd",    {28'b0, alu_cmd},    {28'b0, got.cmd});
    chk32(got.tag, "store_data", store_data,          got.sd);
    chk32(got.tag, "wb_en",      {31'b0, wb_en},      {31'b0, got.wbe});
    chk32(got.tag, "wb_reg",     {27'b0, wb_reg},     {27'b0, got.wbr});
    chk32(got.tag, "mem_rd_wr",  {30'b0, mem_read, mem_write}, {30'b0, got.mr, got.mw});
    chk32(got.tag, "out_valid",  {31'b0, out_valid},  {31'b0, got.ov});
    chk32(got.tag, "illegal",    {31'b0, illegal},    {31'b0, got.ill});
    chk32(got.tag, "illegal_seen", {31'b0, illegal_seen}, {31'b0, got.seen});
    last = got;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t add_e;
    rst_n = 1'b0; instr = '0; in_valid = 1'b0; rs_data = '0; rt_data = '0;
    stall = 1'b0; flush = 1'b0;
    @(negedge clk);

    step(0, 32'h0, 0, 0, 0, 0, 0, bubble("reset", 0));
    step(0, 32'h0022_1820, 1, 5, 7, 0, 0, bubble("reset_hold", 0));

    add_e = mk("add", 5, 7, 0, 7, 1, 3, 0, 0, 1, 0, 0);
    step(1, 32'h0022_1820, 1, 5, 7, 0, 0, add_e);
    step(1, 32'h0002_20C3, 1, 0, 32'h8000_0000, 0, 0,
         mk("sra", 32'h8000_0000, 3, 9, 32'h8000_0000, 1, 4, 0, 0, 1, 0, 0));
    step(1, 32'h2025_FFFF, 1, 10, 3, 0, 0,
         mk("addi", 10, 32'hFFFF_FFFF, 0, 3, 1, 5, 0, 0, 1, 0, 0));
    step(1, 32'h3025_FFFF, 1, 32'h1234_5678, 3, 0, 0,
         mk("andi", 32'h1234_5678, 32'h0000_FFFF, 4, 3, 1, 5, 0, 0, 1, 0, 0));
    step(1, 32'h3C06_1234, 1, 9, 1, 0, 0,
         mk("lui", 32'h1234, 16, 8, 1, 1, 6, 0, 0, 1, 0, 0));
    step(1, 32'hAC22_0004, 1, 32'h100, 32'hCAFE, 0, 0,
         mk("sw", 32'h100, 4, 0, 32'hCAFE, 0, 2, 0, 1, 1, 0, 0));
    step(1, 32'h8C23_FFF8, 1, 32'h100, 0, 0, 0,
         mk("lw", 32'h100, 32'hFFFF_FFF8, 0, 0, 1, 3, 1, 0, 1, 0, 0));
    step(1, 32'h0043_2004, 1, 32'h25, 32'h11, 0, 0,
         mk("sllv", 32'h11, 5, 8, 32'h11, 1, 4, 0, 0, 1, 0, 0));
    step(1, 32'h0043_0027, 1, 6, 9, 0, 0,
         mk("nor_r0", 6, 9, 6, 9, 0, 0, 0, 0, 1, 0, 0));

    add_e.tag = "add2";
    step(1, 32'h0022_1820, 1, 5, 7, 0, 0, add_e);
    for (int i = 0; i < 3; i++) begin
      add_e.tag = "stall_hold";
      step(1, 32'h2025_FFFF, 1, 10, 3, 1, 0, add_e);
    end
    step(1, 32'h2025_FFFF, 1, 10, 3, 1, 1, bubble("stall_flush", 0));
    step(1, 32'h0000_0000, 1, 0, 0, 0, 0,
         mk("nop", 0, 0, 8, 0, 0, 0, 0, 0, 1, 0, 0));
    step(1, 32'h0022_1820, 0, 5, 7, 0, 0, bubble("not_valid", 0));
    step(1, 32'hFC00_0000, 1, 0, 0, 1, 0, bubble("stall_ignores_ill", 0));
    step(1, 32'hFC00_0000, 1, 0, 0, 0, 1, bubble("flush_ignores_ill", 0));

    step(1, 32'hFC00_0000, 1, 4, 0, 0, 0,
         mk("illegal", 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1));
    step(1, 32'h0000_002A, 1, 4, 0, 0, 0,
         mk("illegal_funct", 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1));
    add_e = mk("add_sticky", 5, 7, 0, 7, 1, 3, 0, 0, 1, 0, 1);
    step(1, 32'h0022_1820, 1, 5, 7, 0, 0, add_e);
    step(1, 32'h0022_1820, 1, 5, 7, 0, 1, bubble("flush_keeps_seen", 1));
    step(0, 32'h0022_1820, 1, 5, 7, 0, 0, bubble("reset_clears", 0));
    step(1, 32'h0062_2022, 1, 20, 8, 0, 0,
         mk("sub", 20, 8, 2, 8, 1, 4, 0, 0, 1, 0, 0));
    step(1, 32'h0003_2102, 1, 0, 32'hF000_0000, 0, 0,
         mk("srl", 32'hF000_0000, 4, 10, 32'hF000_0000, 1, 4, 0, 0, 1, 0, 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
